// File: rtl/ram_dma_ci_burst.sv
// Custom-instruction scratch-pad SRAM with a burst DMA engine that owns the second SRAM port.
// Port A is the CPU's single-word path; port B moves blocks between SRAM and system memory.
module ram_dma_ci_burst #(
  parameter logic [7:0]  customId   = 8'h00,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  ciN,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result,
  output logic        busRequest,
  input  logic        busGrant,
  output logic        beginTransaction,
  output logic [31:0] addressDataOut,
  output logic        readNotWrite,
  output logic [7:0]  burstSize,
  output logic        dataValidOut,
  output logic        endTransactionOut,
  input  logic [31:0] addressDataIn,
  input  logic        dataValidIn,
  input  logic        endTransactionIn,
  input  logic        busyIn,
  input  logic        busErrorIn
);

  localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_W     = ADDR_WIDTH + 1;
  localparam int unsigned BW_W      = 9;
  localparam logic [7:0]  BURST_CAP = 8'(MAX_BURST - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_BEGIN, S_RD, S_WR, S_END, S_NEXT
  } state_e;

  logic [31:0] mem [0:DEPTH-1];
  logic [31:0] ram_a_q, ram_b_q;

  state_e                state_q, state_d;
  logic                  busy_q, busy_d, error_q, error_d, rd_pend_q, rd_pend_d;
  logic [31:0]           cfg_bus_q, cfg_bus_d;
  logic [ADDR_WIDTH-1:0] cfg_mem_q, cfg_mem_d;
  logic [CNT_W-1:0]      cfg_block_q, cfg_block_d;
  logic [7:0]            cfg_burst_q, cfg_burst_d;
  logic                  dir_q, dir_d;
  logic [7:0]            dma_burst_q, dma_burst_d;
  logic [31:0]           bus_addr_q, bus_addr_d;
  logic [ADDR_WIDTH-1:0] cur_mem_q, cur_mem_d;
  logic [CNT_W-1:0]      remaining_q, remaining_d;
  logic [BW_W-1:0]       burst_words_q, burst_words_d, burst_cnt_q, burst_cnt_d;
  logic                  bus_req_q, bus_req_d, begin_tr_q, begin_tr_d;
  logic                  rnw_q, rnw_d, end_tr_q, end_tr_d;
  logic [31:0]           addr_data_q, addr_data_d;
  logic [7:0]            burst_size_q, burst_size_d;

  logic                  ci_hit, ci_bad, ci_ok, ci_rd, ci_wr, dma_go;
  logic [3:0]            ci_func;
  logic [ADDR_WIDTH-1:0] ci_addr, ram_b_addr;
  logic                  ram_b_we, wr_xfer;
  logic [BW_W-1:0]       burst_lim, burst_calc;

  // CI decode; any set bit above func makes the instruction a no-op
  always_comb begin
    ci_hit  = start & (ciN == customId);
    ci_bad  = |valueA[31:ADDR_WIDTH+4];
    ci_ok   = ci_hit & ~ci_bad;
    ci_func = valueA[ADDR_WIDTH+3:ADDR_WIDTH];
    ci_addr = valueA[ADDR_WIDTH-1:0];
    ci_rd   = ci_ok & (ci_func == 4'd0);
    ci_wr   = ci_ok & (ci_func == 4'd1);
    dma_go  = ci_ok & (ci_func == 4'd6);
  end

  always_comb begin
    done = (ci_hit & ~ci_rd) | rd_pend_q;
    if (rd_pend_q)
      result = ram_a_q;
    else if (ci_ok && ci_func == 4'd7)
      result = {30'd0, error_q, busy_q};
    else
      result = 32'd0;
  end

  // Next burst length: configured length, clipped to what is left of the block
  always_comb begin
    burst_lim = BW_W'(dma_burst_q) + BW_W'(1);
    if (32'(remaining_q) < 32'(burst_lim))
      burst_calc = BW_W'(remaining_q);
    else
      burst_calc = burst_lim;
  end

  assign wr_xfer = (state_q == S_WR) & ~busyIn;

  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    error_d       = error_q;
    rd_pend_d     = ci_rd;
    cfg_bus_d     = cfg_bus_q;
    cfg_mem_d     = cfg_mem_q;
    cfg_block_d   = cfg_block_q;
    cfg_burst_d   = cfg_burst_q;
    dir_d         = dir_q;
    dma_burst_d   = dma_burst_q;
    bus_addr_d    = bus_addr_q;
    cur_mem_d     = cur_mem_q;
    remaining_d   = remaining_q;
    burst_words_d = burst_words_q;
    burst_cnt_d   = burst_cnt_q;

    if (ci_ok) begin
      case (ci_func)
        4'd2:    cfg_bus_d   = {valueB[31:2], 2'b00};
        4'd3:    cfg_mem_d   = valueB[ADDR_WIDTH-1:0];
        4'd4:    cfg_block_d = valueB[ADDR_WIDTH:0];
        4'd5:    cfg_burst_d = (valueB[7:0] > BURST_CAP) ? BURST_CAP : valueB[7:0];
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (dma_go) begin
          error_d = 1'b0;
          if (cfg_block_q != '0) begin
            state_d     = S_REQ;
            busy_d      = 1'b1;
            bus_addr_d  = cfg_bus_q;
            cur_mem_d   = cfg_mem_q;
            remaining_d = cfg_block_q;
            dma_burst_d = cfg_burst_q;
            dir_d       = valueB[0];
          end
        end
      end
      S_REQ: begin
        if (busGrant) begin
          state_d       = S_BEGIN;
          burst_words_d = burst_calc;
          burst_cnt_d   = burst_calc;
        end
      end
      S_BEGIN: state_d = dir_q ? S_WR : S_RD;
      S_RD: begin
        if (dataValidIn && remaining_q != '0) begin
          cur_mem_d   = cur_mem_q + ADDR_WIDTH'(1);
          remaining_d = remaining_q - CNT_W'(1);
        end
        if (endTransactionIn) state_d = S_NEXT;
      end
      S_WR: begin
        if (wr_xfer) begin
          cur_mem_d   = cur_mem_q + ADDR_WIDTH'(1);
          remaining_d = remaining_q - CNT_W'(1);
          burst_cnt_d = burst_cnt_q - BW_W'(1);
          if (burst_cnt_q == BW_W'(1)) state_d = S_END;
        end
      end
      S_END: state_d = S_NEXT;
      S_NEXT: begin
        bus_addr_d = bus_addr_q + 32'({burst_words_q, 2'b00});
        if (remaining_q != '0) begin
          state_d = S_REQ;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (busErrorIn && state_q != S_IDLE) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      error_d = 1'b1;
    end

    // Bus outputs are registered images of the state being entered
    bus_req_d    = (state_d == S_REQ) || (state_d == S_BEGIN) || (state_d == S_RD) ||
                   (state_d == S_WR)  || (state_d == S_END);
    begin_tr_d   = (state_d == S_BEGIN);
    end_tr_d     = (state_d == S_END);
    rnw_d        = (state_d == S_BEGIN) & ~dir_q;
    addr_data_d  = (state_d == S_BEGIN) ? bus_addr_q : 32'd0;
    burst_size_d = (state_d == S_BEGIN) ? 8'(burst_calc - BW_W'(1)) : 8'd0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      busy_q        <= 1'b0;
      error_q       <= 1'b0;
      rd_pend_q     <= 1'b0;
      cfg_bus_q     <= '0;
      cfg_mem_q     <= '0;
      cfg_block_q   <= '0;
      cfg_burst_q   <= '0;
      dir_q         <= 1'b0;
      dma_burst_q   <= '0;
      bus_addr_q    <= '0;
      cur_mem_q     <= '0;
      remaining_q   <= '0;
      burst_words_q <= '0;
      burst_cnt_q   <= '0;
      bus_req_q     <= 1'b0;
      begin_tr_q    <= 1'b0;
      end_tr_q      <= 1'b0;
      rnw_q         <= 1'b0;
      addr_data_q   <= '0;
      burst_size_q  <= '0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      error_q       <= error_d;
      rd_pend_q     <= rd_pend_d;
      cfg_bus_q     <= cfg_bus_d;
      cfg_mem_q     <= cfg_mem_d;
      cfg_block_q   <= cfg_block_d;
      cfg_burst_q   <= cfg_burst_d;
      dir_q         <= dir_d;
      dma_burst_q   <= dma_burst_d;
      bus_addr_q    <= bus_addr_d;
      cur_mem_q     <= cur_mem_d;
      remaining_q   <= remaining_d;
      burst_words_q <= burst_words_d;
      burst_cnt_q   <= burst_cnt_d;
      bus_req_q     <= bus_req_d;
      begin_tr_q    <= begin_tr_d;
      end_tr_q      <= end_tr_d;
      rnw_q         <= rnw_d;
      addr_data_q   <= addr_data_d;
      burst_size_q  <= burst_size_d;
    end
  end

  // Port B reads ahead to the next word so a write burst never waits on the SRAM
  assign ram_b_addr = (state_q == S_RD) ? cur_mem_q : cur_mem_d;
  assign ram_b_we   = (state_q == S_RD) & dataValidIn & (remaining_q != '0) & ~busErrorIn;

  always_ff @(posedge clock) begin
    if (ci_wr) mem[ci_addr] <= valueB;
    ram_a_q <= mem[ci_addr];
    if (ram_b_we) mem[ram_b_addr] <= addressDataIn;
    ram_b_q <= mem[ram_b_addr];
  end

  assign busRequest        = bus_req_q;
  assign beginTransaction  = begin_tr_q;
  assign readNotWrite      = rnw_q;
  assign burstSize         = burst_size_q;
  assign endTransactionOut = end_tr_q;
  assign dataValidOut      = wr_xfer;
  assign addressDataOut    = (state_q == S_WR) ? ram_b_q : addr_data_q;

endmodule

// File: tb/tb_ram_dma_ci_burst.sv
// Bench for ram_dma_ci_burst: CI vector table plus a bus-slave model with begin/write scoreboards.
module tb_ram_dma_ci_burst;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  ciN = 8'h00;
  logic [31:0] valueA = 32'd0, valueB = 32'd0;
  logic        done;
  logic [31:0] result;
  logic        busRequest, beginTransaction, readNotWrite, dataValidOut, endTransactionOut;
  logic [31:0] addressDataOut;
  logic [7:0]  burstSize;
  logic        busGrant = 1'b0;
  logic [31:0] addressDataIn = 32'd0;
  logic        dataValidIn = 1'b0, endTransactionIn = 1'b0, busyIn = 1'b0, busErrorIn = 1'b0;

  ram_dma_ci_burst #(.customId(8'h00), .ADDR_WIDTH(9), .MAX_BURST(16)) dut (
    .clock(clock), .reset(reset), .start(start), .ciN(ciN), .valueA(valueA), .valueB(valueB),
    .done(done), .result(result), .busRequest(busRequest), .busGrant(busGrant),
    .beginTransaction(beginTransaction), .addressDataOut(addressDataOut),
    .readNotWrite(readNotWrite), .burstSize(burstSize), .dataValidOut(dataValidOut),
    .endTransactionOut(endTransactionOut), .addressDataIn(addressDataIn),
    .dataValidIn(dataValidIn), .endTransactionIn(endTransactionIn), .busyIn(busyIn),
    .busErrorIn(busErrorIn)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic        rnw;
    logic [7:0]  size;
  } begin_t;

  typedef struct {
    logic [3:0]  f;
    logic [8:0]  addr;
    logic [18:0] hi;
    logic [31:0] vb;
    logic [31:0] exp_res;
    int          exp_lat;
    string       name;
  } ci_vec_t;

  int          chk_cnt = 0, err_cnt = 0;
  int          begin_cnt = 0, end_cnt = 0, wr_cnt = 0;
  logic        toggle_en = 1'b0;
  begin_t      exp_begin[$];
  logic [31:0] exp_wr[$];

  function automatic logic [31:0] sys_word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus slave: grants immediately, serves reads from sys_word(), consumes write words
  logic        rd_active = 1'b0;
  int          rd_left = 0;
  logic [31:0] rd_addr = 32'd0;
  always @(negedge clock) begin
    busyIn = toggle_en ? ~busyIn : 1'b0;
    #1;
    busGrant = busRequest;
    if (dataValidOut) begin
      wr_cnt++;
      if (exp_wr.size() == 0) begin
        chk_cnt++;
        err_cnt++;
        $display("FAIL wr_extra: got %h expected no word", addressDataOut);
      end else begin
        chk("wr_word", addressDataOut, exp_wr.pop_front());
      end
    end
    if (endTransactionOut) end_cnt++;
    dataValidIn = 1'b0;
    endTransactionIn = 1'b0;
    addressDataIn = 32'd0;
    if (!busRequest) begin
      rd_active = 1'b0;
    end else if (beginTransaction) begin
      begin_t e;
      begin_cnt++;
      if (exp_begin.size() == 0) begin
        chk_cnt++;
        err_cnt++;
        $display("FAIL begin_extra: got addr %h expected no begin", addressDataOut);
      end else begin
        e = exp_begin.pop_front();
        chk("begin_addr", addressDataOut, e.addr);
        chk("begin_rnw", 32'(readNotWrite), 32'(e.rnw));
        chk("begin_size", 32'(burstSize), 32'(e.size));
      end
      if (readNotWrite) begin
        rd_active = 1'b1;
        rd_left = int'(burstSize) + 1;
        rd_addr = addressDataOut;
      end
    end else if (rd_active) begin
      if (rd_left > 0) begin
        dataValidIn = 1'b1;
        addressDataIn = sys_word(rd_addr);
        rd_addr += 32'd4;
        rd_left--;
      end else begin
        endTransactionIn = 1'b1;
        rd_active = 1'b0;
      end
    end
  end

  task automatic ci(input logic [3:0] f, input logic [8:0] a, input logic [18:0] hi,
                    input logic [31:0] vb, output logic [31:0] res, output int lat);
    res = 32'd0;
    lat = -1;
    @(negedge clock);
    start = 1'b1;
    ciN = 8'h00;
    valueA = {hi, f, a};
    valueB = vb;
    #1;
    if (done) begin
      lat = 0;
      res = result;
    end
    @(posedge clock);
    #1;
    start = 1'b0;
    valueA = 32'd0;
    valueB = 32'd0;
    if (lat < 0) begin
      for (int k = 1; k <= 3; k++) begin
        @(negedge clock);
        #1;
        if (done) begin
          lat = k;
          res = result;
          break;
        end
      end
    end
  endtask

  task automatic cfg(input logic [3:0] f, input logic [31:0] vb);
    logic [31:0] r;
    int l;
    ci(f, 9'd0, 19'd0, vb, r, l);
  endtask

  task automatic wait_idle(input string name);
    logic [31:0] r;
    int l;
    for (int i = 0; i < 3000; i++) begin
      ci(4'd7, 9'd0, 19'd0, 32'd0, r, l);
      if (r[0] == 1'b0) break;
    end
    chk(name, 32'(r[0]), 32'd0);
  endtask

  task automatic wait_begins(input string name, input int target);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (begin_cnt >= target) break;
    end
    chk(name, 32'(begin_cnt), 32'(target));
  endtask

  task automatic check_sram(input string name, input logic [8:0] a, input logic [31:0] exp);
    logic [31:0] r;
    int l;
    ci(4'd0, a, 19'd0, 32'd0, r, l);
    chk(name, r, exp);
  endtask

  ci_vec_t vecs[16];

  initial begin
    logic [31:0] r;
    int l, base, ends0, wr0;

    vecs[0]  = '{4'd1, 9'd5,   19'd0, 32'hDEADBEEF, 32'd0,        0, "wr5"};
    vecs[1]  = '{4'd0, 9'd5,   19'd0, 32'd0,        32'hDEADBEEF, 1, "rd5"};
    vecs[2]  = '{4'd1, 9'd5,   19'd1, 32'h12345678, 32'd0,        0, "wr5_hibits"};
    vecs[3]  = '{4'd0, 9'd5,   19'h40000, 32'd0,    32'd0,        0, "rd5_hibits"};
    vecs[4]  = '{4'd0, 9'd5,   19'd0, 32'd0,        32'hDEADBEEF, 1, "rd5_kept"};
    vecs[5]  = '{4'd1, 9'd511, 19'd0, 32'hA5A55A5A, 32'd0,        0, "wr511"};
    vecs[6]  = '{4'd0, 9'd511, 19'd0, 32'd0,        32'hA5A55A5A, 1, "rd511"};
    vecs[7]  = '{4'd1, 9'd0,   19'd0, 32'h00000001, 32'd0,        0, "wr0"};
    vecs[8]  = '{4'd0, 9'd0,   19'd0, 32'd0,        32'h00000001, 1, "rd0"};
    vecs[9]  = '{4'd7, 9'd0,   19'd0, 32'd0,        32'd0,        0, "status0"};
    vecs[10] = '{4'd9, 9'd3,   19'd0, 32'hFFFFFFFF, 32'd0,        0, "func9"};
    vecs[11] = '{4'd15, 9'd3,  19'd0, 32'hFFFFFFFF, 32'd0,        0, "func15"};
    vecs[12] = '{4'd2, 9'd0,   19'd0, 32'h00001003, 32'd0,        0, "cfg_bus"};
    vecs[13] = '{4'd3, 9'd0,   19'd0, 32'h00000000, 32'd0,        0, "cfg_mem"};
    vecs[14] = '{4'd4, 9'd0,   19'd0, 32'd40,       32'd0,        0, "cfg_block"};
    vecs[15] = '{4'd5, 9'd0,   19'd0, 32'd200,      32'd0,        0, "cfg_burst"};

    // Reset state
    repeat (3) @(negedge clock);
    #1;
    chk("rst_busRequest", 32'(busRequest), 32'd0);
    chk("rst_begin", 32'(beginTransaction), 32'd0);
    chk("rst_addrdata", addressDataOut, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // CI vectors
    for (int i = 0; i < 16; i++) begin
      ci(vecs[i].f, vecs[i].addr, vecs[i].hi, vecs[i].vb, r, l);
      chk({vecs[i].name, "_res"}, r, vecs[i].exp_res);
      chk({vecs[i].name, "_lat"}, 32'(l), 32'(vecs[i].exp_lat));
    end

    // Read DMA 40 words in 16/16/8 bursts; burstLen 200 clamps to 15, busAddr low bits dropped
    exp_begin.push_back('{32'h1000, 1'b1, 8'd15});
    exp_begin.push_back('{32'h1040, 1'b1, 8'd15});
    exp_begin.push_back('{32'h1080, 1'b1, 8'd7});
    ci(4'd6, 9'd0, 19'd0, 32'd0, r, l);
    chk("go_done_lat", 32'(l), 32'd0);
    chk("go_busreq_next", 32'(busRequest), 32'd1);
    wait_idle("rd40_idle");
    chk("rd40_begins", 32'(begin_cnt), 32'd3);
    for (int i = 0; i < 40; i++)
      check_sram("rd40_sram", 9'(i), sys_word(32'h1000 + 32'(4 * i)));
    ci(4'd7, 9'd0, 19'd0, 32'd0, r, l);
    chk("rd40_status", r, 32'd0);

    // Write DMA of 5 words with the slave stalling every other cycle
    for (int i = 0; i < 5; i++) begin
      cfg_sram_wr: begin
        ci(4'd1, 9'(100 + i), 19'd0, 32'h5000_0000 + 32'(i), r, l);
        exp_wr.push_back(32'h5000_0000 + 32'(i));
      end
    end
    cfg(4'd2, 32'h2000);
    cfg(4'd3, 32'd100);
    cfg(4'd4, 32'd5);
    exp_begin.push_back('{32'h2000, 1'b0, 8'd4});
    ends0 = end_cnt;
    wr0 = wr_cnt;
    toggle_en = 1'b1;
    ci(4'd6, 9'd0, 19'd0, 32'd1, r, l);
    wait_idle("wr5_idle");
    toggle_en = 1'b0;
    chk("wr5_words", 32'(wr_cnt - wr0), 32'd5);
    chk("wr5_ends", 32'(end_cnt - ends0), 32'd1);
    chk("wr5_queue", 32'(exp_wr.size()), 32'd0);

    // SRAM address wrap
    cfg(4'd2, 32'h3000);
    cfg(4'd3, 32'd510);
    cfg(4'd4, 32'd4);
    exp_begin.push_back('{32'h3000, 1'b1, 8'd3});
    ci(4'd6, 9'd0, 19'd0, 32'd0, r, l);
    wait_idle("wrap_idle");
    check_sram("wrap_510", 9'd510, sys_word(32'h3000));
    check_sram("wrap_511", 9'd511, sys_word(32'h3004));
    check_sram("wrap_0", 9'd0, sys_word(32'h3008));
    check_sram("wrap_1", 9'd1, sys_word(32'h300C));

    // Bus error during the second burst
    cfg(4'd2, 32'h4000);
    cfg(4'd3, 32'd200);
    cfg(4'd4, 32'd40);
    exp_begin.push_back('{32'h4000, 1'b1, 8'd15});
    exp_begin.push_back('{32'h4040, 1'b1, 8'd15});
    base = begin_cnt;
    ci(4'd6, 9'd0, 19'd0, 32'd0, r, l);
    wait_begins("err_second_begin", base + 2);
    repeat (3) @(negedge clock);
    busErrorIn = 1'b1;
    @(negedge clock);
    #1;
    chk("err_busreq_low", 32'(busRequest), 32'd0);
    busErrorIn = 1'b0;
    ci(4'd7, 9'd0, 19'd0, 32'd0, r, l);
    chk("err_status", r, 32'd2);
    cfg(4'd4, 32'd0);
    ci(4'd6, 9'd0, 19'd0, 32'd0, r, l);
    chk("blk0_done_lat", 32'(l), 32'd0);
    ci(4'd7, 9'd0, 19'd0, 32'd0, r, l);
    chk("blk0_status", r, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      #1;
      chk("blk0_no_req", 32'(busRequest), 32'd0);
    end

    // Second start while busy is ignored but completes
    for (int i = 0; i < 8; i++) begin
      ci(4'd1, 9'(300 + i), 19'd0, 32'h6600_0000 + 32'(i), r, l);
      exp_wr.push_back(32'h6600_0000 + 32'(i));
    end
    cfg(4'd2, 32'h5000);
    cfg(4'd3, 32'd300);
    cfg(4'd4, 32'd8);
    cfg(4'd5, 32'd3);
    exp_begin.push_back('{32'h5000, 1'b0, 8'd3});
    exp_begin.push_back('{32'h5010, 1'b0, 8'd3});
    ends0 = end_cnt;
    ci(4'd6, 9'd0, 19'd0, 32'd1, r, l);
    ci(4'd6, 9'd0, 19'd0, 32'd0, r, l);
    chk("busy_go_lat", 32'(l), 32'd0);
    chk("busy_go_res", r, 32'd0);
    ci(4'd7, 9'd0, 19'd0, 32'd0, r, l);
    chk("busy_status", r, 32'd1);
    wait_idle("busy_idle");
    chk("busy_ends", 32'(end_cnt - ends0), 32'd2);
    chk("busy_queue", 32'(exp_wr.size()), 32'd0);

    // Asynchronous reset in the middle of a read burst
    cfg(4'd5, 32'd15);
    cfg(4'd2, 32'h6000);
    cfg(4'd3, 32'd0);
    cfg(4'd4, 32'd32);
    exp_begin.push_back('{32'h6000, 1'b1, 8'd15});
    base = begin_cnt;
    ci(4'd6, 9'd0, 19'd0, 32'd0, r, l);
    wait_begins("rst_begin_seen", base + 1);
    repeat (4) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("midrst_busreq", 32'(busRequest), 32'd0);
    chk("midrst_begin", 32'(beginTransaction), 32'd0);
    chk("midrst_dvo", 32'(dataValidOut), 32'd0);
    chk("midrst_endout", 32'(endTransactionOut), 32'd0);
    chk("midrst_addrdata", addressDataOut, 32'd0);
    chk("midrst_rnw", 32'(readNotWrite), 32'd0);
    chk("midrst_bsize", 32'(burstSize), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    ci(4'd7, 9'd0, 19'd0, 32'd0, r, l);
    chk("postrst_status", r, 32'd0);
    check_sram("postrst_sram511", 9'd511, sys_word(32'h3004));

    repeat (3) @(negedge clock);
    chk("begin_queue_empty", 32'(exp_begin.size()), 32'd0);
    chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/ram_dma_ci_burst.md
# ram_dma_ci_burst

Parametrised successor to the custom-instruction scratch-pad SRAM. It is a CPU custom-instruction slave that gives the processor single-word access to a local dual-port SRAM of configurable depth. It adds a bus-master DMA engine that moves blocks between SRAM and system memory in bursts, in either direction. Port A of the SRAM serves the CPU; port B belongs exclusively to the DMA engine.

## Interface
- customId, 8'h00: ciN value this instance responds to
- ADDR_WIDTH, 9: SRAM address bits; depth = 2**ADDR_WIDTH words of 32 bits
- MAX_BURST, 16: largest burst in words (power of two, ≤256)
- clock in 1: single clock, all logic rising-edge
- reset in 1: asynchronous, active-low (0 resets); the only reset
- start in 1: CI start strobe
- ciN in 8: CI number
- valueA, valueB in 32: CI operands
- done out 1: CI completion
- result out 32: CI result; 0 whenever done=0
- busRequest out 1: bus request; held until transaction ends
- busGrant in 1: arbiter grant
- beginTransaction out 1: one-cycle transaction start
- addressDataOut out 32: address in begin cycle, write data otherwise
- readNotWrite out 1: 1 = burst read from system memory
- burstSize out 8: words in burst minus 1
- dataValidOut out 1: write word valid
- endTransactionOut out 1: one-cycle end of write burst
- addressDataIn in 32: read data
- dataValidIn in 1: read word valid
- endTransactionIn in 1: slave ends read burst
- busyIn in 1: slave stall for write data
- busErrorIn in 1: bus error

## Operation
- Decode: valueA[ADDR_WIDTH-1:0] = SRAM address; valueA[ADDR_WIDTH+3:ADDR_WIDTH] = func; higher bits nonzero → done same cycle, result 0, no side effect.
- func 0: read SRAM[addr] → result. func 1: write valueB to SRAM[addr]; result 0.
- func 2: busAddr ← valueB (low two bits forced 0). func 3: memAddr ← valueB[ADDR_WIDTH-1:0]. func 4: blockSize ← valueB[ADDR_WIDTH:0] (words, 0..depth). func 5: burstLen ← min(valueB[7:0], MAX_BURST-1).
- func 6: start DMA; valueB[0]=0 → bus→SRAM, 1 → SRAM→bus. Ignored while busy (done still given).
- func 7: status; result = {30'd0, error, busy}. Other funcs: result 0.
- func 2–5 writes while busy go to config registers; they are used at the next func 6.
- FSM: IDLE → (start, blockSize≠0) REQ; blockSize=0 → stays IDLE, busy never set.
- REQ: busRequest=1; on busGrant → BEGIN.
- BEGIN: one cycle with beginTransaction=1, addressDataOut=cur bus address, readNotWrite, burstSize = min(burstLen+1, remaining)-1 → RD or WR.
- RD: each dataValidIn writes addressDataIn to SRAM[curMem] via port B; curMem+1 mod depth; remaining−1. On endTransactionIn → NEXT.
- WR: words are prefetched from port B. dataValidOut=1 with the word while busyIn=0. Word and counters are held while busyIn=1. After the last word of the burst → END.
- END: endTransactionOut=1 one cycle → NEXT.
- NEXT: busRequest low. Bus address += 4×burst words. remaining>0 → REQ, else IDLE, busy←0.
- busErrorIn in any non-IDLE state → IDLE immediately: busRequest dropped, error←1, busy←0. error clears at next accepted func 6.
- SRAM addresses wrap mod depth. The bus address wraps at 2^32.
- Simultaneous CI write and DMA write to the same SRAM word leaves the word undefined; software must avoid it. Different addresses are always safe.

## Timing
- Reset: all outputs 0; config, counters, busy, error 0; FSM IDLE. The SRAM contents are not cleared.
- Reset mid-transfer aborts immediately and asynchronously; no endTransactionOut is produced.
- func 0: done one cycle after start, with result valid in that cycle. All other funcs: done in the start cycle.
- func 6 accepted at cycle t → busy=1 and busRequest=1 at t+1.
- beginTransaction is exactly one cycle, in the first cycle busGrant is seen high in REQ.
- First write word is no earlier than the cycle after BEGIN.
- busy falls the cycle after NEXT of the final burst.

## Test plan
- CI write 0xDEADBEEF to addr 5, read addr 5 → done one cycle later, result 0xDEADBEEF. valueA[31:13]≠0 → done, result 0, SRAM unchanged.
- busAddr=0x1000, memAddr=0, blockSize=40, burstLen=15, bus→SRAM with model slave → three read bursts of 16/16/8 at 0x1000/0x1040/0x1080. SRAM[0..39] matches; status reads 0 after.
- SRAM→bus, blockSize=5, busyIn toggling every other cycle → exactly 5 dataValidOut words in order, no duplicates, one endTransactionOut.
- memAddr=depth-2, blockSize=4 → SRAM writes land at depth-2, depth-1, 0, 1.
- busErrorIn in second burst → busRequest low next cycle, status=2. New func 6 clears error. blockSize=0 start → no busRequest.
- Second func 6 while busy → ignored, done given. reset=0 mid-burst → all bus outputs 0 and status 0 after release.
